// File: rtl/mem_arbiter.sv
// mem_arbiter: three-requester memory arbiter (vid > cmd/cpu round-robin) with a one-outstanding-access FSM.
// Define MEM_ARBITER_AUTO_REFRESH_EN to add the refresh timer, top-priority refresh and overrun flag.
module mem_arbiter #(
   parameter int REFRESH_INTERVAL = 420
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        vid_req,
   input  logic [22:0] vid_addr,
   input  logic [1:0]  vid_size,
   output logic        vid_ack,
   output logic        vid_rvalid,
   input  logic        cmd_req,
   input  logic [22:0] cmd_addr,
   input  logic [1:0]  cmd_size,
   input  logic        cmd_wr,
   input  logic [31:0] cmd_din32,
   output logic        cmd_ack,
   output logic        cmd_rvalid,
   input  logic        cpu_req,
   input  logic [22:0] cpu_addr,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_din8,
   output logic        cpu_ack,
   output logic        cpu_rvalid,
   output logic [31:0] rdata32,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_refresh,
   output logic [22:0] mem_addr,
   output logic [1:0]  mem_word_size,
   output logic [7:0]  mem_din8,
   output logic [31:0] mem_din32,
   input  logic [31:0] mem_dout32,
   input  logic        mem_busy,
   output logic        refresh_overrun
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   localparam logic [1:0] SRC_REF = 2'd0, SRC_VID = 2'd1, SRC_CMD = 2'd2, SRC_CPU = 2'd3;

   state_t      state_q, state_d;
   logic [1:0]  src_q, src_d, size_q, size_d;
   logic        wr_q, wr_d, rr_q, rr_d;
   logic [22:0] addr_q, addr_d;
   logic [7:0]  din8_q, din8_d;
   logic [31:0] din32_q, din32_d, rdata_q, rdata_d;
   logic [2:0]  rvalid_q, rvalid_d;
   logic        ref_pend, issue, win_cmd;

   assign issue = state_q == ISSUE;
   // rr_q set means cmd was served last, so cpu wins the next tie
   assign win_cmd = cmd_req & (~cpu_req | ~rr_q);

`ifdef MEM_ARBITER_AUTO_REFRESH_EN
   localparam int CW = $clog2(REFRESH_INTERVAL + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d, ovr_q, ovr_d, wrap, ref_issue;
   assign ref_issue = issue & (src_q == SRC_REF);
   always_comb begin
      wrap   = cnt_q == CW'(REFRESH_INTERVAL - 1);
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      pend_d = wrap | (pend_q & ~ref_issue);
      ovr_d  = ovr_q | (wrap & pend_q & ~ref_issue);
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
      end
   end
   assign ref_pend        = pend_q;
   assign refresh_overrun = ovr_q;
   assign mem_refresh     = ref_issue;
`else
   localparam int unused_refresh_interval = REFRESH_INTERVAL;
   assign ref_pend        = 1'b0;
   assign refresh_overrun = 1'b0;
   assign mem_refresh     = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      wr_d     = wr_q;
      rr_d     = rr_q;
      addr_d   = addr_q;
      size_d   = size_q;
      din8_d   = din8_q;
      din32_d  = din32_q;
      rdata_d  = rdata_q;
      rvalid_d = 3'b000;
      case (state_q)
         IDLE: if (!mem_busy && (ref_pend || vid_req || cmd_req || cpu_req)) begin
            state_d = ISSUE;
            src_d   = ref_pend ? SRC_REF : vid_req ? SRC_VID : win_cmd ? SRC_CMD : SRC_CPU;
            wr_d    = (src_d == SRC_CMD && cmd_wr) || (src_d == SRC_CPU && cpu_wr);
            addr_d  = src_d == SRC_VID ? vid_addr : src_d == SRC_CMD ? cmd_addr :
                      src_d == SRC_CPU ? cpu_addr : '0;
            size_d  = src_d == SRC_VID ? vid_size : src_d == SRC_CMD ? cmd_size :
                      src_d == SRC_CPU ? cpu_size : '0;
            din8_d  = (src_d == SRC_CPU && cpu_wr) ? cpu_din8 : '0;
            din32_d = (src_d == SRC_CMD && cmd_wr) ? cmd_din32 : '0;
            rr_d    = src_d == SRC_CMD ? 1'b1 : src_d == SRC_CPU ? 1'b0 : rr_q;
         end
         ISSUE: state_d = WAIT;
         WAIT: if (!mem_busy) begin
            state_d = IDLE;
            if (!wr_q && src_q != SRC_REF) begin
               rdata_d  = mem_dout32;
               rvalid_d = {src_q == SRC_VID, src_q == SRC_CMD, src_q == SRC_CPU};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         src_q    <= SRC_REF;
         wr_q     <= 1'b0;
         rr_q     <= 1'b0;
         addr_q   <= '0;
         size_q   <= '0;
         din8_q   <= '0;
         din32_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         wr_q     <= wr_d;
         rr_q     <= rr_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         din8_q   <= din8_d;
         din32_q  <= din32_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign mem_read      = issue & ~wr_q & (src_q != SRC_REF);
   assign mem_write     = issue & wr_q;
   assign mem_addr      = addr_q;
   assign mem_word_size = size_q;
   assign mem_din8      = din8_q;
   assign mem_din32     = din32_q;
   assign vid_ack       = issue & (src_q == SRC_VID);
   assign cmd_ack       = issue & (src_q == SRC_CMD);
   assign cpu_ack       = issue & (src_q == SRC_CPU);
   assign vid_rvalid    = rvalid_q[2];
   assign cmd_rvalid    = rvalid_q[1];
   assign cpu_rvalid    = rvalid_q[0];
   assign rdata32       = rdata_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 420, clk cycles between auto-refresh requests (7.8 us at 54 MHz).
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have, for each requester p in {vid, cmd, cpu}, ports p_req in 1 (level request), p_addr in 23 (byte address), p_size in 2 (8/16/32 word-size code), p_ack out 1 (grant pulse), p_rvalid out 1 (read-data pulse).
REQ-005 SHALL have ports cmd_wr in 1, cmd_din32 in 32, cpu_wr in 1, cpu_din8 in 8; vid is read-only.
REQ-006 SHALL have port rdata32  output  32  read data shared by all requesters.
REQ-007 SHALL have memory-side ports mem_read out 1, mem_write out 1, mem_refresh out 1, mem_addr out 23, mem_word_size out 2, mem_din8 out 8, mem_din32 out 32, mem_dout32 in 32, mem_busy in 1.
REQ-008 SHALL have port refresh_overrun  output  1  sticky refresh-deadline-miss flag.

Function
REQ-009 SHALL implement states IDLE, ISSUE, WAIT; registered state.
REQ-010 IDLE with mem_busy=0 and any pending source SHALL latch winner, its addr/size/data/direction, go ISSUE.
REQ-011 Priority SHALL be refresh > vid > {cmd, cpu}; cmd/cpu SHALL round-robin, last-served loses ties; after reset cmd wins first tie.
REQ-012 ISSUE SHALL assert exactly one of mem_read/mem_write/mem_refresh for one cycle, with mem_addr/mem_word_size/mem_din* from latched values, pulse winner p_ack same cycle, go WAIT.
REQ-013 Grant-to-command latency SHALL be 1 cycle (winner sampled cycle T, command and p_ack at T+1).
REQ-014 WAIT SHALL hold until mem_busy=0; for a read, SHALL then register mem_dout32 into rdata32 and pulse winner p_rvalid one cycle later; go IDLE.
REQ-015 rdata32 SHALL hold its value until the next completed read.
REQ-016 Requesters SHALL hold p_req and operands stable until p_ack; a p_req deasserted before grant SHALL be dropped without side effects.
REQ-017 A requester SHALL not be granted again until its own p_rvalid (reads) or the WAIT exit (writes) of the prior access.
REQ-018 mem_din8 SHALL carry cpu_din8 for cpu writes; mem_din32 SHALL carry cmd_din32 for cmd writes; unused data outputs SHALL be 0.
REQ-019 No memory command SHALL be issued while mem_busy=1, including after reset until the controller clears busy.
REQ-020 Simultaneous refresh expiry and requests SHALL grant refresh first.
REQ-021 All memory command and ack outputs SHALL be 0 outside ISSUE; p_rvalid 0 except its one pulse.

Reset
REQ-022 resetn low SHALL force IDLE, all pulses/commands 0, mem_addr/mem_word_size/mem_din*/rdata32 0, refresh_overrun 0, refresh counter 0, refresh pending 0, round-robin pointer to cmd.
REQ-023 Reset mid-ISSUE/WAIT SHALL abandon the access; no p_ack/p_rvalid SHALL follow.

Configuration
REQ-024 Macro MEM_ARBITER_AUTO_REFRESH_EN defined: counter 0..REFRESH_INTERVAL-1 wraps, sets refresh pending at wrap; pending cleared when mem_refresh issued; a wrap while still pending SHALL set refresh_overrun until reset.
REQ-025 Macro undefined: no counter, mem_refresh and refresh_overrun tied 0, priority vid > {cmd, cpu}.

Verification
REQ-026 After reset, mem_busy 1 for 20 cycles then 0; cpu_req write addr 0x000101 din8 0xA5 -> no command while busy; then mem_write, mem_addr 0x000101, mem_din8 0xA5, cpu_ack same cycle.
REQ-027 vid_req read addr 0x000400 size 32, model returns 0x12345678 -> vid_ack 1 cycle after sample, vid_rvalid with rdata32 0x12345678 one cycle after mem_busy falls.
REQ-028 cmd_req and cpu_req held together for 4 accesses -> grants cmd, cpu, cmd, cpu; vid_req asserted mid-sequence -> vid granted at next IDLE.
REQ-029 With macro, REFRESH_INTERVAL 16, idle -> mem_refresh every 16 cycles; hold mem_busy 40 cycles -> refresh_overrun 1 and stays 1.
REQ-030 Assert resetn low during WAIT of cpu read -> all outputs 0, no cpu_rvalid afterwards; new request served normally after release.
